lookup_send: RTL and testbench
==============================

Name: lookup_send

Overview:
- Transmit-side counterpart of the Huffman lookup-table loader.
- Walks the encoder's code-table register file and serializes every valid entry to the UART transmitter as 3 bytes: char, {path[3:0], length}, path[11:4].
- Then sends a 3-byte terminator so the far-end loader can detect end of table.
- Sits between the code-table registers and the UART TX block; started by the encode controller before payload transmission.

Parameters:
- NUM_ENTRIES, 256, number of table slots scanned (addresses 0..NUM_ENTRIES-1).
- ADDR_W, 8, width of rd_addr; must satisfy 2^ADDR_W >= NUM_ENTRIES.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a table send. Ignored unless in IDLE.
- rd_en  out  1  table read strobe.
- rd_addr  out  ADDR_W  table slot address.
- rd_char  in  8  character of the addressed slot; valid the cycle after rd_en.
- rd_length  in  4  code length; 0 = unused slot.
- rd_path  in  12  code path bits; only bits [rd_length-1:0] meaningful.
- tx_ready  in  1  UART TX can accept a byte.
- tx_load  out  1  one-cycle pulse; tx_data is valid in the same cycle.
- tx_data  out  8  byte to transmit.
- busy  out  1  high from the cycle after start until DONE is left.
- table_done  out  1  one-cycle pulse when the final byte has been loaded.

Behaviour:
- Reset values: rd_en=0, rd_addr=0, tx_load=0, tx_data=0, busy=0, table_done=0.
- Reset: internal latches cleared; FSM to IDLE. Reset mid-send aborts immediately; no further tx_load is issued.
- State machine:
  - IDLE: on start, set addr=0 and go to FETCH.
  - FETCH: assert rd_en with rd_addr=addr; go to LATCH.
  - LATCH: capture rd_char, rd_length and rd_path into registers.
    - rd_length==0: go to NEXT (slot skipped, no bytes sent).
    - Otherwise: go to SEND0.
  - SEND0 / SEND1 / SEND2:
    - Wait for tx_ready=1, then pulse tx_load for one cycle and go to the matching GAPn.
    - Bytes: SEND0 = char; SEND1 = {path[3:0], length[3:0]}; SEND2 = path[11:4].
  - GAP0 / GAP1 / GAP2: one mandatory cycle in which tx_ready is ignored, covering TX's registered ready deassert. Then go to SEND1, SEND2, or NEXT respectively.
  - NEXT:
    - addr==NUM_ENTRIES-1: go to TERM0.
    - Otherwise: addr+1, then FETCH.
  - TERM0 / TERM1 / TERM2: same load/gap handshake as SENDn. Terminator bytes are 8'h00, 8'h0F, 8'h00 (char 0, length 15, path 0). Length 15 is reserved as the end marker; the table never holds a real length-15 entry.
  - DONE: pulse table_done for 1 cycle; go to IDLE.
- tx_data holds its last value between loads. It is only meaningful while tx_load=1.
- Address counter is ADDR_W wide; no wrap occurs because the FSM exits at NUM_ENTRIES-1.
- start during a send is ignored.
- start in the same cycle as DONE is ignored; it must be re-issued from IDLE.
- Empty table (all lengths 0): only the terminator is sent.
- Per-entry latency, with tx_ready held high: FETCH, LATCH, then 3×(SEND+GAP) = 8 cycles.
- Skipped slot costs 3 cycles: FETCH, LATCH, NEXT.

Optional Feature:
- Macro: LOOKUP_SEND_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR accumulates every byte loaded, terminator included.
  - The accumulator is cleared on start.
  - After TERM2/GAP, states CSUM and a following GAP send the accumulator value as one extra byte.
  - table_done pulses only after that byte is loaded.
- Not defined: no accumulator and no CSUM state; the terminator is the last byte.

Test Plan:
- NUM_ENTRIES=4; slot1 = char 8'h41, len 3, path 12'h005; all other slots len 0; tx_ready tied 1; start -> tx_data sequence 41, 53, 00, 00, 0F, 00. table_done pulses 1 cycle after the last tx_load.
- All slots len 0 -> exactly 3 tx_loads (00, 0F, 00); busy returns to 0.
- Slot0 = char 8'hFF, len 12, path 12'hABC; tx_ready held low 10 cycles before each byte -> bytes FF, CC, AB. tx_load never fires while tx_ready=0. Exactly one tx_load per byte.
- Assert n_rst low after the 2nd tx_load -> all outputs return to reset values asynchronously. After release and a new start, the send restarts from slot 0.
- start pulsed again mid-send -> no effect; the byte count matches a single send.
- With LOOKUP_SEND_CHECKSUM_EN and the first test's table -> a 7th byte equal to 41^53^00^00^0F^00 = 8'h1D is sent before table_done.

Source files
------------

// File: rtl/lookup_send.sv
// lookup_send: walks the Huffman code-table register file and serializes every
// valid entry to the UART transmitter as three bytes
//   char, {path[3:0], length}, path[11:4]
// followed by the terminator 8'h00, 8'h0F, 8'h00 (length 15 marks end of table).
//
// Optional build macro: LOOKUP_SEND_CHECKSUM_EN
//   When defined, a running XOR of every loaded byte (terminator included) is
//   sent as one extra byte after the terminator, before table_done pulses.
//
// Handshake: tx_load is raised in the same cycle that tx_ready is seen high in
// a SEND/TERM/CSUM state, so the UART latches tx_data on that edge. The cycle
// after every load ignores tx_ready, covering the UART's registered ready drop.
// For the last byte of the stream, DONE is that cycle, so table_done appears
// exactly one cycle after the final tx_load.
module lookup_send #(
  parameter int NUM_ENTRIES = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_char,
  input  logic [3:0]        rd_length,
  input  logic [11:0]       rd_path,
  input  logic              tx_ready,
  output logic              tx_load,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              table_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

  localparam logic [7:0] TERM_BYTE0 = 8'h00;
  localparam logic [7:0] TERM_BYTE1 = 8'h0F;
  localparam logic [7:0] TERM_BYTE2 = 8'h00;

  typedef enum logic [4:0] {
    S_IDLE  = 5'd0,
    S_FETCH = 5'd1,
    S_LATCH = 5'd2,
    S_SEND0 = 5'd3,
    S_GAP0  = 5'd4,
    S_SEND1 = 5'd5,
    S_GAP1  = 5'd6,
    S_SEND2 = 5'd7,
    S_GAP2  = 5'd8,
    S_NEXT  = 5'd9,
    S_TERM0 = 5'd10,
    S_TGAP0 = 5'd11,
    S_TERM1 = 5'd12,
    S_TGAP1 = 5'd13,
    S_TERM2 = 5'd14,
`ifdef LOOKUP_SEND_CHECKSUM_EN
    S_TGAP2 = 5'd15,
    S_CSUM  = 5'd16,
`endif
    S_DONE  = 5'd17
  } state_t;

  // Only the low rd_length bits of a path carry code bits; upper bits are
  // forced to zero so the far end always sees a deterministic byte.
  function automatic logic [11:0] path_mask(input logic [3:0] len);
    path_mask = (12'h001 << len) - 12'h001;
  endfunction

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         char_q;
  logic [3:0]         len_q;
  logic [11:0]        path_q;
  logic [7:0]         tx_data_q;
  logic               rd_en_q;
  logic               busy_q;
  logic               table_done_q;
  logic               load_s;
  logic [7:0]         byte_s;
`ifdef LOOKUP_SEND_CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  // Next-state, address and byte-select decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    load_s  = 1'b0;
    byte_s  = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = {ADDR_W{1'b0}};
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (rd_length == 4'd0) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_SEND0;
        end
      end
      S_SEND0: begin
        byte_s = char_q;
        if (tx_ready) begin
          load_s  = 1'b1;
          state_d = S_GAP0;
        end else begin
          state_d = S_SEND0;
        end
      end
      S_GAP0: state_d = S_SEND1;
      S_SEND1: begin
        byte_s = {path_q[3:0], len_q};
        if (tx_ready) begin
          load_s  = 1'b1;
          state_d = S_GAP1;
        end else begin
          state_d = S_SEND1;
        end
      end
      S_GAP1: state_d = S_SEND2;
      S_SEND2: begin
        byte_s = path_q[11:4];
        if (tx_ready) begin
          load_s  = 1'b1;
          state_d = S_GAP2;
        end else begin
          state_d = S_SEND2;
        end
      end
      S_GAP2: state_d = S_NEXT;
      S_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_TERM0;
        end else begin
          addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_d = S_FETCH;
        end
      end
      S_TERM0: begin
        byte_s = TERM_BYTE0;
        if (tx_ready) begin
          load_s  = 1'b1;
          state_d = S_TGAP0;
        end else begin
          state_d = S_TERM0;
        end
      end
      S_TGAP0: state_d = S_TERM1;
      S_TERM1: begin
        byte_s = TERM_BYTE1;
        if (tx_ready) begin
          load_s  = 1'b1;
          state_d = S_TGAP1;
        end else begin
          state_d = S_TERM1;
        end
      end
      S_TGAP1: state_d = S_TERM2;
      S_TERM2: begin
        byte_s = TERM_BYTE2;
        if (tx_ready) begin
          load_s  = 1'b1;
`ifdef LOOKUP_SEND_CHECKSUM_EN
          state_d = S_TGAP2;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_TERM2;
        end
      end
`ifdef LOOKUP_SEND_CHECKSUM_EN
      S_TGAP2: state_d = S_CSUM;
      S_CSUM: begin
        byte_s = csum_q;
        if (tx_ready) begin
          load_s  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_CSUM;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and address registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Capture the addressed slot; the table answers one cycle after rd_en.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      char_q <= 8'h00;
      len_q  <= 4'h0;
      path_q <= 12'h000;
    end else if (state_q == S_LATCH) begin
      char_q <= rd_char;
      len_q  <= rd_length;
      path_q <= rd_path & path_mask(rd_length);
    end else begin
      char_q <= char_q;
      len_q  <= len_q;
      path_q <= path_q;
    end
  end

  // Hold the last loaded byte so tx_data is stable between loads.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_data_q <= 8'h00;
    end else if (load_s) begin
      tx_data_q <= byte_s;
    end else begin
      tx_data_q <= tx_data_q;
    end
  end

`ifdef LOOKUP_SEND_CHECKSUM_EN
  // Running XOR of every streamed byte; cleared when a send starts and not
  // folded with itself when the checksum byte goes out.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      csum_q <= 8'h00;
    end else if ((state_q == S_IDLE) && start) begin
      csum_q <= 8'h00;
    end else if (load_s && (state_q != S_CSUM)) begin
      csum_q <= csum_q ^ byte_s;
    end else begin
      csum_q <= csum_q;
    end
  end
`endif

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      table_done_q <= 1'b0;
    end else begin
      rd_en_q      <= (state_d == S_FETCH);
      busy_q       <= (state_d != S_IDLE);
      table_done_q <= (state_d == S_DONE);
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = addr_q;
  assign busy       = busy_q;
  assign table_done = table_done_q;
  assign tx_load    = load_s;
  assign tx_data    = load_s ? byte_s : tx_data_q;

endmodule

// File: tb/tb_lookup_send.sv
// Directed bench for lookup_send with a scoreboard of expected UART bytes.
module tb_lookup_send;
  localparam int NE = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_char = 8'h00;
  logic [3:0]    rd_length = 4'h0;
  logic [11:0]   rd_path = 12'h000;
  logic          tx_ready;
  logic          tx_load;
  logic [7:0]    tx_data;
  logic          busy;
  logic          table_done;

  int checks = 0;
  int fails  = 0;
  int n_loads = 0;
  int cyc = 0;
  int last_load_cyc = -10;

  logic [7:0]  sb[$];
  logic [7:0]  m_char[NE];
  logic [3:0]  m_len[NE];
  logic [11:0] m_path[NE];

  lookup_send #(.NUM_ENTRIES(NE), .ADDR_W(AW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_char(rd_char), .rd_length(rd_length), .rd_path(rd_path),
    .tx_ready(tx_ready), .tx_load(tx_load), .tx_data(tx_data),
    .busy(busy), .table_done(table_done)
  );

  always #5 clk = ~clk;

  // Table register file model: answers one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_char   <= m_char[rd_addr];
      rd_length <= m_len[rd_addr];
      rd_path   <= m_path[rd_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every load, checks done timing.
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (tx_load === 1'b1) begin
      chk("load_while_ready", {31'd0, tx_ready}, 32'd1);
      n_loads++;
      last_load_cyc = cyc;
      if (sb.size() > 0) e = sb.pop_front();
      else e = 8'hxx;
      chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
    end
    if (table_done === 1'b1) begin
      chk("done_latency", cyc, last_load_cyc + 1);
    end
  end

  task automatic set_table(input int idx, input logic [7:0] c, input logic [3:0] l, input logic [11:0] p);
    m_char[idx] = c;
    m_len[idx]  = l;
    m_path[idx] = p;
  endtask

  task automatic clear_table();
    for (int i = 0; i < NE; i++) set_table(i, 8'h00, 4'h0, 12'h000);
  endtask

  // Expected byte stream for the current table contents.
  task automatic push_expected();
    logic [7:0]  cs;
    logic [11:0] p;
    logic [7:0]  b[3];
    cs = 8'h00;
    for (int i = 0; i < NE; i++) begin
      if (m_len[i] != 4'd0) begin
        p = m_path[i] & ((12'h001 << m_len[i]) - 12'h001);
        b[0] = m_char[i];
        b[1] = {p[3:0], m_len[i]};
        b[2] = p[11:4];
        for (int k = 0; k < 3; k++) begin
          sb.push_back(b[k]);
          cs = cs ^ b[k];
        end
      end
    end
    sb.push_back(8'h00);
    sb.push_back(8'h0F);
    sb.push_back(8'h00);
    cs = cs ^ 8'h0F;
`ifdef LOOKUP_SEND_CHECKSUM_EN
    sb.push_back(cs);
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (table_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"},      {31'd0, rd_en}, 32'd0);
    chk({tag, "_rd_addr"},    {30'd0, rd_addr}, 32'd0);
    chk({tag, "_tx_load"},    {31'd0, tx_load}, 32'd0);
    chk({tag, "_tx_data"},    {24'd0, tx_data}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy}, 32'd0);
    chk({tag, "_table_done"}, {31'd0, table_done}, 32'd0);
  endtask

  // Full send with tx_ready high; checks count, drain and busy release.
  task automatic run_send(input string tag);
    int  base;
    int  nb;
    bit  got;
    push_expected();
    nb = sb.size();
    base = n_loads;
    pulse_start();
    wait_done(400, got);
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_load_count"}, n_loads - base, nb);
    chk({tag, "_sb_drained"}, sb.size(), 0);
    @(negedge clk);
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int  base;
    int  nb;
    int  seen;
    bit  got;
    n_rst = 1'b0;
    start = 1'b0;
    tx_ready = 1'b1;
    clear_table();
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;

    // One valid entry in slot 1.
    clear_table();
    set_table(1, 8'h41, 4'd3, 12'h005);
    run_send("one_entry");

    // Empty table: terminator only.
    clear_table();
    run_send("empty");

    // Slot 0 fully populated, tx_ready throttled 10 cycles before each byte.
    clear_table();
    set_table(0, 8'hFF, 4'd12, 12'hABC);
    push_expected();
    nb = sb.size();
    base = n_loads;
    tx_ready = 1'b0;
    pulse_start();
    for (int b = 0; b < nb; b++) begin
      repeat (10) @(posedge clk);
      #1 tx_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (tx_load === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      chk("throttle_load_seen", {31'd0, got}, 32'd1);
      @(posedge clk); #1 tx_ready = 1'b0;
    end
    wait_done(20, got);
    chk("throttle_done_seen", {31'd0, got}, 32'd1);
    chk("throttle_load_count", n_loads - base, nb);
    chk("throttle_sb_drained", sb.size(), 0);
    tx_ready = 1'b1;

    // Asynchronous reset after the second load, then a clean restart.
    clear_table();
    set_table(1, 8'h41, 4'd3, 12'h005);
    push_expected();
    pulse_start();
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx_load === 1'b1) seen++;
      if (seen >= 2) break;
    end
    chk("abort_two_loads", seen, 2);
    #2 n_rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    sb.delete();
    base = n_loads;
    repeat (5) @(negedge clk);
    chk("abort_no_loads", n_loads, base);
    @(posedge clk); #1 n_rst = 1'b1;
    run_send("restart");

    // Second start mid-send must not add a send.
    push_expected();
    nb = sb.size();
    base = n_loads;
    pulse_start();
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(400, got);
    chk("restart_ignored_done", {31'd0, got}, 32'd1);
    chk("restart_ignored_count", n_loads - base, nb);
    repeat (40) @(negedge clk);
    chk("restart_ignored_quiet", n_loads - base, nb);
    chk("restart_ignored_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
